axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
- AXI4 slave responder backing a word-addressed on-chip SRAM model; the target end of the fetch/LSU AXI4 masters in the NPC core.
- Independent read and write engines with programmable response latency, single-beat and INCR/FIXED bursts, byte-strobed writes, and SLVERR/DECERR error responses.
- Sits behind the arbiter or is connected directly to the IFU for standalone simulation.

Parameters:
- BASE_ADDR, 32'h3000_0000, first byte address decoded by this slave
- DEPTH, 4096, number of 32-bit words (power of two)
- RD_LATENCY, 2, idle cycles between AR handshake and first R beat
- WR_LATENCY, 1, idle cycles between the last W handshake and BVALID

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- awvalid in 1 / awready out 1 / awaddr in 32 / awid in 4 / awlen in 8 / awsize in 3 / awburst in 2: write address channel
- wvalid in 1 / wready out 1 / wdata in 32 / wstrb in 4 / wlast in 1: write data channel
- bvalid out 1 / bready in 1 / bresp out 2 / bid out 4: write response channel
- arvalid in 1 / arready out 1 / araddr in 32 / arid in 4 / arlen in 8 / arsize in 3 / arburst in 2: read address channel
- rvalid out 1 / rready in 1 / rdata out 32 / rresp out 2 / rlast out 1 / rid out 4: read data channel

Behaviour:
- While reset is high, every output is 0, both FSMs are forced to IDLE, and the latency counters are cleared. Reset asserted mid-burst aborts the burst without a response; memory contents are retained.
- Read FSM: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - arready = 1 only in R_IDLE.
  - The AR handshake latches addr, id, len, burst and loads cnt = RD_LATENCY. If RD_LATENCY = 0, go directly to R_DATA.
  - R_WAIT decrements cnt to 0, then moves to R_DATA.
  - First rvalid is registered at T+1+RD_LATENCY, where T is the AR handshake cycle.
  - rdata, rresp, rid and rlast are held stable while rvalid && !rready.
  - Beat index advances on rvalid && rready. rlast = (beat == len). The final handshake returns to R_IDLE; arready is high on the following cycle, with no back-to-back AR acceptance in the same cycle.
- Address progression:
  - INCR (2'b01): +4 per beat.
  - FIXED (2'b00): same address every beat.
  - WRAP (2'b10) and reserved (2'b11): full burst length is still returned, with rresp = SLVERR and rdata = 0.
- Decode: index = (addr - BASE_ADDR) >> 2. If addr < BASE_ADDR or index >= DEPTH:
  - Reads: that beat returns DECERR (2'b11) with data 0.
  - Writes: the write is dropped and bresp = DECERR.
- awsize/arsize other than 3'b010 -> SLVERR for the whole transaction; writes are dropped.
- Write FSM: W_IDLE -> W_DATA -> W_WAIT -> W_RESP -> W_IDLE.
  - awready = 1 only in W_IDLE.
  - wready = 1 only in W_DATA.
  - Each W handshake writes the bytes enabled by wstrb[i] to byte lane i.
  - A beat is last when wlast = 1 or the beat count reaches awlen. If these disagree, the burst still terminates on whichever occurs first and bresp = SLVERR.
  - W_WAIT counts WR_LATENCY cycles (skipped when 0). W_RESP drives bvalid with bid = awid and holds until bready.
- Simultaneous same-word read beat and write beat: the write commits at the clock edge and the read returns the old data (read-before-write).
- rresp/bresp priority: DECERR > SLVERR > OKAY.

Optional Feature:
- AXI4_SRAM_RAND_DELAY_EN
  - Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1, reset to seed) replaces RD_LATENCY and WR_LATENCY at each handshake with lfsr[2:0]. Additionally, rvalid is withheld for one cycle between burst beats whenever lfsr[3] = 1.
  - Undefined: fixed latencies and back-to-back beats.

Decomposition:
- Package axi4_pkg:
  - burst encodings BURST_FIXED / BURST_INCR / BURST_WRAP
  - response codes RESP_OKAY / RESP_EXOKAY / RESP_SLVERR / RESP_DECERR
  - SIZE_4B
  - read/write FSM state enums
- One sub-module: axi4_sram_lfsr, instantiated only under the macro.
- Memory array and decode remain inline.

Test Plan:
- Reset, then AR addr 32'h3000_0000 len 0 INCR with RD_LATENCY = 2 -> rvalid at T+3, rdata = mem[0], rresp 00, rlast 1, rid echoed.
- AW 32'h3000_0010 len 3 INCR, wdata 1..4, wstrb 4'hF, then AR with the same parameters -> bresp 00, bvalid T+2 after wlast handshake; read returns 1, 2, 3, 4 with rlast on the 4th beat.
- Write wstrb 4'b0101 data 32'hAABBCCDD over 32'h11223344 -> read returns 32'h11BB33DD.
- rready held low for 5 cycles mid-burst -> rdata and rlast stable throughout, no beat lost or duplicated.
- araddr 32'h2FFF_FFFC -> DECERR with rdata 0. AW len 1 with wlast on beat 0 -> bresp SLVERR.
- arburst WRAP len 3 -> 4 beats with SLVERR. Reset pulsed during R_WAIT -> rvalid never asserts and arready returns high 1 cycle after reset falls.

Source files
------------

// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 burst/response encodings, transfer size and FSM state types for the SRAM slave
package axi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_4B = 3'b010;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
endpackage

// File: rtl/axi4_sram_lfsr.sv
// axi4_sram_lfsr: free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11), seeded 16'hACE1 on reset
// Ports: clock, reset (sync, active-high), lfsr (current state)
module axi4_sram_lfsr (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);
  always_ff @(posedge clock)
    lfsr <= reset ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
endmodule

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave over a word-addressed SRAM with independent read/write engines
// Ports: clock, reset (sync, active-high); AW/W/B write channels; AR/R read channels (32-bit data, 4-bit id).
// Macro AXI4_SRAM_RAND_DELAY_EN: LFSR-driven response latencies and random gaps between read beats.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int DEPTH = 4096,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [7:0] rd_lat, wr_lat;
  logic gap;
`ifdef AXI4_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;
  axi4_sram_lfsr u_lfsr (.clock(clock), .reset(reset), .lfsr(lfsr));
  assign rd_lat = {5'd0, lfsr[2:0]};
  assign wr_lat = {5'd0, lfsr[2:0]};
  assign gap = lfsr[3];
`else
  assign rd_lat = 8'(RD_LATENCY);
  assign wr_lat = 8'(WR_LATENCY);
  assign gap = 1'b0;
`endif
  function automatic logic dec_err(input logic [31:0] a);
    return a < BASE_ADDR || ((a - BASE_ADDR) >> 2) >= 32'(DEPTH);
  endfunction
  function automatic logic [AW-1:0] idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction
  r_state_t r_state;
  logic [31:0] r_addr, r_step, r_eval;
  logic [7:0] r_len, r_beat, r_cnt;
  logic [1:0] r_burst, beat_resp;
  logic r_size_err, r_eval_err;
  logic [31:0] beat_data;
  assign r_step = r_burst == BURST_INCR ? r_addr + 32'd4 : r_addr;
  // Beat being loaded into the R registers: first beat straight from AR, next beat while presenting the current one
  always_comb begin
    r_eval = r_state == R_IDLE ? araddr : (r_state == R_DATA && rvalid) ? r_step : r_addr;
    r_eval_err = r_state == R_IDLE ? (arsize != SIZE_4B || arburst[1]) : (r_size_err || r_burst[1]);
    beat_resp = dec_err(r_eval) ? RESP_DECERR : r_eval_err ? RESP_SLVERR : RESP_OKAY;
    beat_data = beat_resp == RESP_OKAY ? mem[idx(r_eval)] : 32'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      {arready, rvalid, rlast, rdata, rresp, rid} <= '0;
      {r_addr, r_len, r_beat, r_cnt, r_burst, r_size_err} <= '0;
    end else if (r_state == R_IDLE) begin
      arready <= !(arvalid && arready);
      if (arvalid && arready) begin
        {r_addr, rid, r_len, r_burst} <= {araddr, arid, arlen, arburst};
        r_size_err <= arsize != SIZE_4B;
        r_beat <= '0;
        r_cnt <= rd_lat;
        r_state <= rd_lat == 8'd0 ? R_DATA : R_WAIT;
        if (rd_lat == 8'd0) {rvalid, rdata, rresp, rlast} <= {1'b1, beat_data, beat_resp, arlen == 8'd0};
      end
    end else if (r_state == R_WAIT) begin
      r_cnt <= r_cnt - 8'd1;
      if (r_cnt == 8'd1) begin
        r_state <= R_DATA;
        {rvalid, rdata, rresp, rlast} <= {1'b1, beat_data, beat_resp, r_len == 8'd0};
      end
    end else if (!rvalid) rvalid <= 1'b1;
    else if (rready && rlast) begin
      rvalid <= 1'b0;
      r_state <= R_IDLE;
      arready <= 1'b1;
    end else if (rready) begin
      r_addr <= r_step;
      r_beat <= r_beat + 8'd1;
      {rvalid, rdata, rresp, rlast} <= {!gap, beat_data, beat_resp, 8'(r_beat + 8'd1) == r_len};
    end
  end
  w_state_t w_state;
  logic [31:0] w_addr;
  logic [7:0] w_len, w_beat, w_cnt;
  logic [1:0] w_burst, bresp_n;
  logic w_slv, w_dec, w_hs, w_last, w_mis, w_ok;
  // w_slv before the final beat only reflects size/burst errors, so it doubles as the drop flag
  assign w_hs = w_state == W_DATA && wvalid && wready && !reset;
  assign w_last = wlast || w_beat == w_len;
  assign w_mis = wlast != (w_beat == w_len);
  assign w_ok = !w_slv && !dec_err(w_addr);
  assign bresp_n = (w_dec || dec_err(w_addr)) ? RESP_DECERR : (w_slv || w_mis) ? RESP_SLVERR : RESP_OKAY;
  always_ff @(posedge clock)
    if (w_hs && w_ok)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      {awready, wready, bvalid, bresp, bid} <= '0;
      {w_addr, w_len, w_beat, w_cnt, w_burst, w_slv, w_dec} <= '0;
    end else if (w_state == W_IDLE) begin
      awready <= !(awvalid && awready);
      if (awvalid && awready) begin
        {w_addr, bid, w_len, w_burst} <= {awaddr, awid, awlen, awburst};
        {w_beat, w_dec} <= '0;
        w_slv <= awsize != SIZE_4B || awburst[1];
        wready <= 1'b1;
        w_state <= W_DATA;
      end
    end else if (w_state == W_DATA) begin
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        w_addr <= w_burst == BURST_INCR ? w_addr + 32'd4 : w_addr;
        w_dec <= w_dec || dec_err(w_addr);
        if (w_last) begin
          wready <= 1'b0;
          bresp <= bresp_n;
          w_cnt <= wr_lat;
          bvalid <= wr_lat == 8'd0;
          w_state <= wr_lat == 8'd0 ? W_RESP : W_WAIT;
        end
      end
    end else if (w_state == W_WAIT) begin
      w_cnt <= w_cnt - 8'd1;
      if (w_cnt == 8'd1) begin
        bvalid <= 1'b1;
        w_state <= W_RESP;
      end
    end else if (bready) begin
      bvalid <= 1'b0;
      awready <= 1'b1;
      w_state <= W_IDLE;
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: scoreboard bench for axi4_sram_slave with default latencies
module tb_axi4_sram_slave;
  import axi4_pkg::*;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clock = 1'b0, reset = 1'b1;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0] awid = '0, wstrb = '0, bid, arid = '0, rid;
  logic [7:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic [3:0] id;} bbeat_t;
  rbeat_t rq[$];
  bbeat_t bq[$];
  int checks = 0, fails = 0, cyc = 0;
  logic ar_hs, aw_hs, w_hs;
  logic [31:0] model [0:63];
  axi4_sram_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );
  always #5 clock = ~clock;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    rbeat_t e;
    bbeat_t b;
    if (rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL r_extra: unexpected beat data=%h resp=%0d last=%0b id=%0d", rdata, rresp, rlast, rid);
      end else begin
        e = rq.pop_front();
        if ({rdata, rresp, rlast, rid} !== e) begin
          fails++;
          $display("FAIL r_beat: got data=%h resp=%0d last=%0b id=%0d, expected data=%h resp=%0d last=%0b id=%0d",
                   rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
        end
      end
    end
    if (bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL b_extra: unexpected response resp=%0d id=%0d", bresp, bid);
      end else begin
        b = bq.pop_front();
        if ({bresp, bid} !== b) begin
          fails++;
          $display("FAIL b_resp: got resp=%0d id=%0d, expected resp=%0d id=%0d", bresp, bid, b.resp, b.id);
        end
      end
    end
    ar_hs = arvalid && arready;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask
  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    k = int'((a - BASE) >> 2) & 63;
    for (int b = 0; b < 4; b++) if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, output int t);
    {araddr, arid, arlen, arburst, arsize} = {a, id, len, burst, size};
    arvalid = 1;
    t = -1;
    for (int n = 0; n < 50 && t < 0; n++) begin
      tick();
      if (ar_hs) t = cyc - 1;
    end
    arvalid = 0;
    checks++;
    if (t < 0) begin fails++; $display("FAIL ar_timeout: arready=%0b, required 1", arready); end
  endtask
  task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int t;
    {awaddr, awid, awlen, awburst, awsize} = {a, id, len, burst, size};
    awvalid = 1;
    t = -1;
    for (int n = 0; n < 50 && t < 0; n++) begin
      tick();
      if (aw_hs) t = cyc - 1;
    end
    awvalid = 0;
    checks++;
    if (t < 0) begin fails++; $display("FAIL aw_timeout: awready=%0b, required 1", awready); end
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last, output int t);
    {wdata, wstrb, wlast} = {d, s, last};
    wvalid = 1;
    t = -1;
    for (int n = 0; n < 50 && t < 0; n++) begin
      tick();
      if (w_hs) t = cyc - 1;
    end
    wvalid = 0;
    checks++;
    if (t < 0) begin fails++; $display("FAIL w_timeout: wready=%0b, required 1", wready); end
  endtask
  task automatic drain();
    rready = 1;
    bready = 1;
    for (int n = 0; n < 200 && (rq.size() != 0 || bq.size() != 0); n++) tick();
    rready = 0;
    bready = 0;
    checks++;
    if (rq.size() != 0 || bq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d R and %0d B outstanding, required 0", rq.size(), bq.size());
    end
  endtask
  task automatic test_reset();
    @(negedge clock);
    repeat (3) tick();
    checks++;
    if ({arready, awready, wready, bvalid, rvalid, rlast, rdata, rresp, rid, bresp, bid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: arready=%0b awready=%0b wready=%0b bvalid=%0b rvalid=%0b rdata=%h, required all 0",
               arready, awready, wready, bvalid, rvalid, rdata);
    end
    reset = 0;
    tick();
    checks++;
    if ({arready, awready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_release: arready=%0b awready=%0b, required 1 1", arready, awready);
    end
  endtask
  task automatic test_single();
    int t;
    send_aw(BASE, 4'h5, 8'd0, BURST_INCR, SIZE_4B);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, t);
    mwrite(BASE, 32'hDEADBEEF, 4'hF);
    bq.push_back({RESP_OKAY, 4'h5});
    drain();
    send_ar(BASE, 4'h3, 8'd0, BURST_INCR, SIZE_4B, t);
    for (int n = 0; n < 10 && !rvalid; n++) tick();
    checks++;
    if (cyc - t != 3) begin fails++; $display("FAIL r_latency: rvalid at T+%0d, required T+3", cyc - t); end
    rq.push_back({model[0], RESP_OKAY, 1'b1, 4'h3});
    drain();
  endtask
  task automatic test_burst();
    int t;
    send_aw(BASE + 32'h10, 4'h2, 8'd3, BURST_INCR, SIZE_4B);
    for (int i = 0; i < 4; i++) begin
      send_w(32'(i + 1), 4'hF, i == 3, t);
      mwrite(BASE + 32'h10 + 32'(4 * i), 32'(i + 1), 4'hF);
    end
    for (int n = 0; n < 10 && !bvalid; n++) tick();
    checks++;
    if (cyc - t != 2) begin fails++; $display("FAIL b_latency: bvalid at T+%0d, required T+2", cyc - t); end
    bq.push_back({RESP_OKAY, 4'h2});
    drain();
    send_ar(BASE + 32'h10, 4'h4, 8'd3, BURST_INCR, SIZE_4B, t);
    for (int i = 0; i < 4; i++) rq.push_back({model[4 + i], RESP_OKAY, i == 3, 4'h4});
    drain();
  endtask
  task automatic test_strobe();
    int t;
    send_aw(BASE + 32'h20, 4'h1, 8'd0, BURST_INCR, SIZE_4B);
    send_w(32'h11223344, 4'hF, 1'b1, t);
    bq.push_back({RESP_OKAY, 4'h1});
    drain();
    send_aw(BASE + 32'h20, 4'h1, 8'd0, BURST_INCR, SIZE_4B);
    send_w(32'hAABBCCDD, 4'b0101, 1'b1, t);
    bq.push_back({RESP_OKAY, 4'h1});
    drain();
    mwrite(BASE + 32'h20, 32'h11BB33DD, 4'hF);
    send_ar(BASE + 32'h20, 4'hE, 8'd0, BURST_INCR, SIZE_4B, t);
    rq.push_back({32'h11BB33DD, RESP_OKAY, 1'b1, 4'hE});
    drain();
  endtask
  task automatic test_stall();
    int t;
    logic [39:0] snap;
    send_ar(BASE + 32'h10, 4'h6, 8'd3, BURST_INCR, SIZE_4B, t);
    for (int i = 0; i < 4; i++) rq.push_back({model[4 + i], RESP_OKAY, i == 3, 4'h6});
    rready = 1;
    for (int n = 0; n < 20 && rq.size() > 2; n++) tick();
    rready = 0;
    snap = {rvalid, rdata, rresp, rlast, rid};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({rvalid, rdata, rresp, rlast, rid} !== snap || snap[39] !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: rvalid=%0b rdata=%h rlast=%0b, required rvalid=1 rdata=%h rlast=%0b",
                 rvalid, rdata, rlast, snap[38:7], snap[4]);
      end
    end
    drain();
    rready = 1;
    repeat (3) tick();
    rready = 0;
  endtask
  task automatic test_errors();
    int t;
    send_ar(32'h2FFF_FFFC, 4'h7, 8'd0, BURST_INCR, SIZE_4B, t);
    rq.push_back({32'd0, RESP_DECERR, 1'b1, 4'h7});
    drain();
    send_ar(BASE + 32'h4000, 4'h8, 8'd0, BURST_INCR, SIZE_4B, t);
    rq.push_back({32'd0, RESP_DECERR, 1'b1, 4'h8});
    drain();
    send_ar(BASE, 4'h9, 8'd1, BURST_INCR, 3'b000, t);
    rq.push_back({32'd0, RESP_SLVERR, 1'b0, 4'h9});
    rq.push_back({32'd0, RESP_SLVERR, 1'b1, 4'h9});
    drain();
    send_aw(BASE + 32'h30, 4'hA, 8'd1, BURST_INCR, SIZE_4B);
    send_w(32'h0BAD0BAD, 4'hF, 1'b1, t);
    bq.push_back({RESP_SLVERR, 4'hA});
    drain();
    send_aw(BASE + 32'h34, 4'hB, 8'd0, BURST_INCR, SIZE_4B);
    send_w(32'h0BAD0BAD, 4'hF, 1'b0, t);
    bq.push_back({RESP_SLVERR, 4'hB});
    drain();
    send_aw(32'h2FFF_FFF0, 4'hC, 8'd0, BURST_INCR, SIZE_4B);
    send_w(32'h0BAD0BAD, 4'hF, 1'b1, t);
    bq.push_back({RESP_DECERR, 4'hC});
    drain();
    send_aw(BASE + 32'h10, 4'hD, 8'd0, BURST_INCR, 3'b001);
    send_w(32'h0BAD0BAD, 4'hF, 1'b1, t);
    bq.push_back({RESP_SLVERR, 4'hD});
    drain();
    send_ar(BASE + 32'h10, 4'hD, 8'd0, BURST_INCR, SIZE_4B, t);
    rq.push_back({model[4], RESP_OKAY, 1'b1, 4'hD});
    drain();
  endtask
  task automatic test_bursts_wrap_fixed();
    int t;
    send_ar(BASE + 32'h10, 4'hC, 8'd3, BURST_WRAP, SIZE_4B, t);
    for (int i = 0; i < 4; i++) rq.push_back({32'd0, RESP_SLVERR, i == 3, 4'hC});
    drain();
    send_ar(BASE + 32'h14, 4'h2, 8'd2, BURST_FIXED, SIZE_4B, t);
    for (int i = 0; i < 3; i++) rq.push_back({model[5], RESP_OKAY, i == 2, 4'h2});
    drain();
  endtask
  task automatic test_reset_mid();
    int t;
    send_ar(BASE, 4'h1, 8'd0, BURST_INCR, SIZE_4B, t);
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (arready !== 1'b0 || rvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: arready=%0b rvalid=%0b, required 0 0", arready, rvalid);
    end
    tick();
    checks++;
    if (arready !== 1'b1) begin fails++; $display("FAIL reset_mid_arready: arready=%0b, required 1", arready); end
    rready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_mid_rvalid: rvalid=%0b, required 0", rvalid); end
      tick();
    end
    rready = 0;
    send_ar(BASE, 4'h1, 8'd0, BURST_INCR, SIZE_4B, t);
    rq.push_back({model[0], RESP_OKAY, 1'b1, 4'h1});
    drain();
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_stall();
    test_errors();
    test_bursts_wrap_fixed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
